aes_input_loader: RTL and testbench
===================================

AES_INPUT_LOADER -- requirements
Module: aes_input_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 128-bit plaintext blocks buffered (power of 2, at least 2).
REQ-002 SHALL have parameter KEYGEN_WAIT, default 11, meaning the idle cycles after the priming start before the first real start.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  the single clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_word  in  32  input word; word 0 of a block or key is bits [127:96], word 3 is bits [31:0].
REQ-007 in_valid  in  1  in_word is valid.
REQ-008 in_is_key  in  1  1 = key word, 0 = plaintext word; qualified by in_valid.
REQ-009 in_ready  out  1  the word is accepted when in_valid and in_ready are both high.
REQ-010 halt_req  in  1  abort request.
REQ-011 eng_set_key  out  1  set_key strobe to the encrypt engine.
REQ-012 eng_key  out  128  assembled key.
REQ-013 eng_start  out  1  start strobe to the engine; one block per high cycle.
REQ-014 eng_state  out  128  block to the engine; valid while eng_start is high.
REQ-015 eng_halt  out  1  halt strobe to the engine.
REQ-016 eng_prime  out  1  high with eng_start when the block is the priming block; the downstream consumer discards the matching output.
REQ-017 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of buffered blocks.
REQ-018 busy  out  1  high when the FSM is not in IDLE.

Function
REQ-019 FSM states SHALL be IDLE, KEY_ASM, SET_KEY, PRIME, WAIT and STREAM.
REQ-020 IDLE -> KEY_ASM on the first accepted key word.
REQ-021 KEY_ASM -> SET_KEY on acceptance of key word 3 (key_cnt 3 -> 0).
REQ-022 SET_KEY SHALL drive eng_set_key=1 for exactly one cycle, then go to PRIME.
REQ-023 PRIME SHALL drive eng_start=1, eng_prime=1 and eng_state=0 for exactly one cycle, then go to WAIT.
REQ-024 WAIT SHALL hold for KEYGEN_WAIT cycles using a down-counter, then go to STREAM.
REQ-025 STREAM SHALL pop one block per cycle while fifo_level is not 0 and drive it on eng_state with eng_start=1 and eng_prime=0 in the same cycle.
REQ-026 STREAM SHALL drive eng_start=0 when the FIFO is empty; there is no timeout.
REQ-027 Key words SHALL be accepted only in IDLE or KEY_ASM; in_ready=0 for key words in every other state.
REQ-028 Plaintext words SHALL be assembled by an independent 2-bit data_cnt in every state, including IDLE.
REQ-029 On acceptance of data word 3, the assembled block SHALL be pushed to the FIFO.
REQ-030 For a plaintext word, in_ready SHALL be 0 only when data_cnt==3 and the FIFO is full; a same-cycle pop does not free space for that cycle.
REQ-031 Simultaneous push and pop while not full SHALL leave fifo_level unchanged.
REQ-032 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 fifo_level SHALL never exceed FIFO_DEPTH or go below 0.
REQ-034 halt_req=1 in any non-IDLE state SHALL on the next edge:
  - drive eng_halt=1 for one cycle;
  - flush the FIFO (level 0);
  - clear key_cnt and data_cnt;
  - return to IDLE.
REQ-035 halt_req in IDLE SHALL clear key_cnt and data_cnt, flush the FIFO, and not assert eng_halt.
REQ-036 halt_req SHALL have priority over every other transition and over any word accepted in the same cycle; that word is dropped.
REQ-037 eng_set_key, eng_start, eng_halt and eng_prime SHALL be mutually exclusive in every cycle.
REQ-038 eng_key SHALL hold its value from SET_KEY until the next key assembly completes.

Reset
REQ-039 rst=1 SHALL force:
  - FSM to IDLE;
  - key_cnt, data_cnt, FIFO pointers and the WAIT counter to 0;
  - eng_key and the data assembly register to 0.
REQ-040 During and after reset, all strobe outputs SHALL be 0, eng_state=0, fifo_level=0 and busy=0.
REQ-041 Reset asserted mid-operation SHALL behave identically to power-on reset, with no eng_halt pulse.

Verification
REQ-042 Key load: key words 00010203, 04050607, 08090a0b, 0c0d0e0f -> exactly:
  - eng_set_key one cycle with eng_key=000102030405060708090a0b0c0d0e0f;
  - the next cycle eng_start=1, eng_prime=1, eng_state=0;
  - then 11 idle cycles.
REQ-043 Stream: plaintext 00112233445566778899aabbccddeeff pre-loaded in IDLE -> first non-prime eng_start exactly 12 cycles after the prime, eng_state=00112233445566778899aabbccddeeff, eng_prime=0.
REQ-044 Back-pressure: 5 blocks sent during WAIT with FIFO_DEPTH=4 -> fifo_level reaches 4 and in_ready=0 on word 3 of block 5; the word is accepted the cycle after the first STREAM pop; all 5 blocks leave in order.
REQ-045 Halt: halt_req in STREAM with fifo_level=3 -> next cycle eng_halt=1 for one cycle, fifo_level=0, busy=0; a following key load repeats the REQ-042 sequence.
REQ-046 Policy: key word in STREAM -> in_ready=0 and no state change; plaintext word 2 plus halt_req in the same cycle -> word dropped and data_cnt=0.
REQ-047 Reset: rst for one cycle in WAIT -> all outputs 0, busy=0, no eng_halt pulse.

Source files
------------

// File: rtl/aes_input_loader.sv
// aes_input_loader
// Collects 32-bit words from a single input stream and turns them into
// 128-bit keys and 128-bit plaintext blocks for an AES encrypt engine.
// Key words are assembled and sent to the engine with a set_key strobe.
// The loader then issues one priming start (all-zero block, flagged with
// eng_prime) and waits KEYGEN_WAIT cycles for the engine's key expansion.
// After that it streams buffered plaintext blocks, one per cycle.
// Plaintext is assembled and buffered in a FIFO in every state, so it can
// be pre-loaded before the key arrives.
//
// Ports
//   clk         : single clock, rising edge
//   rst         : synchronous active-high reset
//   in_word     : input word (word 0 = bits [127:96], word 3 = bits [31:0])
//   in_valid    : in_word is valid
//   in_is_key   : 1 = key word, 0 = plaintext word
//   in_ready    : word accepted when in_valid && in_ready
//   halt_req    : abort request (flushes everything, returns to IDLE)
//   eng_set_key : one-cycle set_key strobe, eng_key valid
//   eng_key     : assembled key, held until the next key completes
//   eng_start   : one block per high cycle
//   eng_state   : block for the engine, valid while eng_start is high
//   eng_halt    : one-cycle halt strobe to the engine
//   eng_prime   : marks the priming start (its output is discarded)
//   fifo_level  : number of buffered plaintext blocks
//   busy        : FSM is not in IDLE
module aes_input_loader #(
  parameter int FIFO_DEPTH  = 4,
  parameter int KEYGEN_WAIT = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 in_word,
  input  logic                        in_valid,
  input  logic                        in_is_key,
  output logic                        in_ready,
  input  logic                        halt_req,
  output logic                        eng_set_key,
  output logic [127:0]                eng_key,
  output logic                        eng_start,
  output logic [127:0]                eng_state,
  output logic                        eng_halt,
  output logic                        eng_prime,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int LVL_W       = PTR_W + 1;
  localparam int WAIT_W      = (KEYGEN_WAIT > 1) ? $clog2(KEYGEN_WAIT) : 1;
  localparam int WAIT_LOAD_I = (KEYGEN_WAIT > 0) ? (KEYGEN_WAIT - 1) : 0;

  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_ZERO  = LVL_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(0);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_LOAD_I);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KEY_ASM = 3'd1,
    SET_KEY = 3'd2,
    PRIME   = 3'd3,
    WAIT    = 3'd4,
    STREAM  = 3'd5
  } state_t;

  state_t             state_r;
  logic [1:0]         key_cnt_r;
  logic [1:0]         data_cnt_r;
  logic [95:0]        key_buf_r;
  logic [95:0]        data_buf_r;
  logic [127:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic               eng_set_key_r;
  logic               eng_start_r;
  logic               eng_halt_r;
  logic               eng_prime_r;
  logic               busy_r;
  logic [127:0]       eng_key_r;
  logic [127:0]       eng_state_r;

  logic               key_ok_s;
  logic               full_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               key_acc_s;
  logic               data_acc_s;
  logic               push_s;
  logic               key_done_s;
  logic               pop_s;
  logic [127:0]       push_data_s;
  logic [LVL_W-1:0]   lvl_after_pop_s;
  logic [LVL_W-1:0]   lvl_next_s;
  logic [PTR_W-1:0]   rd_next_s;
  logic [127:0]       head_s;
  logic               stream_start_s;
  logic [127:0]       stream_state_s;

  // Handshake decode and FIFO look-ahead for the next streamed block
  always_comb begin
    key_ok_s = (state_r == IDLE) || (state_r == KEY_ASM);
    full_s   = (level_r == FULL_LVL);
    if (in_is_key) begin
      in_ready_s = key_ok_s;
    end else begin
      // Only the word that completes a block needs a free FIFO slot.
      in_ready_s = !((data_cnt_r == 2'd3) && full_s);
    end
    // A halt in the same cycle drops the word.
    accept_s    = in_valid && in_ready_s && !halt_req;
    key_acc_s   = accept_s && in_is_key;
    data_acc_s  = accept_s && !in_is_key;
    push_s      = data_acc_s && (data_cnt_r == 2'd3);
    key_done_s  = key_acc_s && (state_r == KEY_ASM) && (key_cnt_r == 2'd3);
    push_data_s = {data_buf_r, in_word};
    // The block shown with eng_start leaves the FIFO at the end of that cycle.
    pop_s = (state_r == STREAM) && eng_start_r;
    if (pop_s) begin
      lvl_after_pop_s = level_r - LVL_ONE;
      rd_next_s       = rd_ptr_r + PTR_ONE;
    end else begin
      lvl_after_pop_s = level_r;
      rd_next_s       = rd_ptr_r;
    end
    if (push_s) begin
      lvl_next_s = lvl_after_pop_s + LVL_ONE;
    end else begin
      lvl_next_s = lvl_after_pop_s;
    end
    // When the FIFO drains to zero this edge, the only candidate head is the
    // block being written right now, so bypass the storage array.
    if (lvl_after_pop_s == LVL_ZERO) begin
      head_s = push_data_s;
    end else begin
      head_s = fifo_mem_r[rd_next_s];
    end
    stream_start_s = (lvl_next_s != LVL_ZERO);
    if (stream_start_s) begin
      stream_state_s = head_s;
    end else begin
      stream_state_s = 128'd0;
    end
  end

  // FSM with registered engine strobes, word assembly and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      key_cnt_r     <= 2'd0;
      data_cnt_r    <= 2'd0;
      key_buf_r     <= 96'd0;
      data_buf_r    <= 96'd0;
      wr_ptr_r      <= PTR_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      level_r       <= LVL_ZERO;
      wait_cnt_r    <= WAIT_ZERO;
      eng_key_r     <= 128'd0;
      eng_state_r   <= 128'd0;
      eng_set_key_r <= 1'b0;
      eng_start_r   <= 1'b0;
      eng_halt_r    <= 1'b0;
      eng_prime_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else if (halt_req) begin
      // Abort wins over everything; the engine is only told when it was active.
      eng_halt_r    <= (state_r != IDLE);
      eng_set_key_r <= 1'b0;
      eng_start_r   <= 1'b0;
      eng_prime_r   <= 1'b0;
      eng_state_r   <= 128'd0;
      state_r       <= IDLE;
      busy_r        <= 1'b0;
      key_cnt_r     <= 2'd0;
      data_cnt_r    <= 2'd0;
      wait_cnt_r    <= WAIT_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      level_r       <= LVL_ZERO;
    end else begin
      eng_set_key_r <= 1'b0;
      eng_start_r   <= 1'b0;
      eng_halt_r    <= 1'b0;
      eng_prime_r   <= 1'b0;
      eng_state_r   <= 128'd0;

      if (key_acc_s) begin
        key_buf_r <= {key_buf_r[63:0], in_word};
        key_cnt_r <= key_cnt_r + 2'd1;
      end
      if (data_acc_s) begin
        data_buf_r <= {data_buf_r[63:0], in_word};
        data_cnt_r <= data_cnt_r + 2'd1;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_next_s;
      level_r  <= lvl_next_s;

      case (state_r)
        IDLE: begin
          if (key_acc_s) begin
            state_r <= KEY_ASM;
            busy_r  <= 1'b1;
          end
        end
        KEY_ASM: begin
          if (key_done_s) begin
            state_r       <= SET_KEY;
            eng_key_r     <= {key_buf_r, in_word};
            eng_set_key_r <= 1'b1;
          end
        end
        SET_KEY: begin
          state_r     <= PRIME;
          eng_start_r <= 1'b1;
          eng_prime_r <= 1'b1;
        end
        PRIME: begin
          if (KEYGEN_WAIT == 0) begin
            state_r     <= STREAM;
            eng_start_r <= stream_start_s;
            eng_state_r <= stream_state_s;
          end else begin
            state_r    <= WAIT;
            wait_cnt_r <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wait_cnt_r == WAIT_ZERO) begin
            state_r     <= STREAM;
            eng_start_r <= stream_start_s;
            eng_state_r <= stream_state_s;
          end else begin
            wait_cnt_r <= wait_cnt_r - WAIT_ONE;
          end
        end
        STREAM: begin
          eng_start_r <= stream_start_s;
          eng_state_r <= stream_state_s;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage: the completed block is written at the write pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 128'd0;
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  assign in_ready    = in_ready_s;
  assign eng_set_key = eng_set_key_r;
  assign eng_key     = eng_key_r;
  assign eng_start   = eng_start_r;
  assign eng_state   = eng_state_r;
  assign eng_halt    = eng_halt_r;
  assign eng_prime   = eng_prime_r;
  assign fifo_level  = level_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_aes_input_loader.sv
// Directed self-checking bench for aes_input_loader (FIFO_DEPTH=4,
// KEYGEN_WAIT=11). Inputs change 1 time unit after the rising edge and
// outputs are read there or on the falling edge.
module tb_aes_input_loader;

  logic         clk;
  logic         rst;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_is_key;
  logic         in_ready;
  logic         halt_req;
  logic         eng_set_key;
  logic [127:0] eng_key;
  logic         eng_start;
  logic [127:0] eng_state;
  logic         eng_halt;
  logic         eng_prime;
  logic [2:0]   fifo_level;
  logic         busy;

  int checks;
  int failures;
  int excl_viol;
  logic [127:0] pops [$];

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BYP = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;
  logic [127:0] blk [5];

  aes_input_loader #(.FIFO_DEPTH(4), .KEYGEN_WAIT(11)) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
    .in_is_key(in_is_key), .in_ready(in_ready), .halt_req(halt_req),
    .eng_set_key(eng_set_key), .eng_key(eng_key), .eng_start(eng_start),
    .eng_state(eng_state), .eng_halt(eng_halt), .eng_prime(eng_prime),
    .fifo_level(fifo_level), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect streamed (non-prime) blocks and watch strobe exclusivity
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_start && !eng_prime) pops.push_back(eng_state);
      if ((int'(eng_set_key) + int'(eng_start) + int'(eng_halt) > 1) ||
          (eng_prime && !eng_start)) excl_viol++;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic k);
    in_valid  = 1'b1;
    in_word   = w;
    in_is_key = k;
    tick();
    in_valid  = 1'b0;
    in_is_key = 1'b0;
    in_word   = 32'd0;
  endtask

  task automatic send_block(input logic [127:0] b);
    for (int j = 0; j < 4; j++) send_word(b[127-32*j -: 32], 1'b0);
  endtask

  task automatic send_key(input logic [127:0] k);
    for (int j = 0; j < 4; j++) send_word(k[127-32*j -: 32], 1'b1);
  endtask

  // Key load, set_key, prime, 11 idle cycles; returns in the first STREAM cycle
  task automatic key_load_check(input string tag);
    int idle;
    send_key(KEY);
    check({tag, "_setkey"}, eng_set_key, 1);
    check({tag, "_key"}, eng_key, KEY);
    check({tag, "_setkey_nostart"}, eng_start, 0);
    tick();
    check({tag, "_prime_start"}, {eng_start, eng_prime, eng_set_key}, 3'b110);
    check({tag, "_prime_state"}, eng_state, 128'd0);
    idle = 0;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (!eng_start && !eng_set_key && !eng_halt && !eng_prime) idle++;
    end
    check({tag, "_wait_idle"}, idle, 11);
    tick();
  endtask

  initial begin
    logic [127:0] tmp;
    logic [127:0] wd;
    logic         rdy;
    int base, idx, cyc, blocked, maxlvl;
    checks = 0; failures = 0; excl_viol = 0;
    blk[0] = 128'h10101010_11111111_12121212_13131313;
    blk[1] = 128'h20202020_21212121_22222222_23232323;
    blk[2] = 128'h30303030_31313131_32323232_33333333;
    blk[3] = 128'h40404040_41414141_42424242_43434343;
    blk[4] = 128'h50505050_51515151_52525252_53535353;
    rst = 1'b1; halt_req = 1'b0; in_valid = 1'b0; in_is_key = 1'b0; in_word = 32'd0;
    tick(); tick();
    check("rst_strobes", {eng_set_key, eng_start, eng_halt, eng_prime}, 4'b0000);
    check("rst_state", eng_state, 128'd0);
    check("rst_key", eng_key, 128'd0);
    check("rst_level_busy", {fifo_level, busy}, 4'b0000);
    rst = 1'b0;
    tick();

    // Pre-load in IDLE, then key load and first streamed block
    send_block(PT0);
    check("preload_level", fifo_level, 1);
    check("preload_busy", busy, 0);
    key_load_check("k1");
    check("stream_start", {eng_start, eng_prime}, 2'b10);
    check("stream_data", eng_state, PT0);
    tick();
    check("stream_drained", {eng_start, fifo_level}, 4'b0000);
    check("stream_busy", busy, 1);

    // Block completed while streaming from an empty FIFO
    send_block(BYP);
    check("byp_start", eng_start, 1);
    check("byp_data", eng_state, BYP);
    check("byp_level", fifo_level, 1);
    tick();
    check("byp_done", eng_start, 0);

    // Key word in STREAM is refused
    in_valid = 1'b1; in_is_key = 1'b1; in_word = 32'hdeadbeef;
    #1;
    check("key_in_stream_ready", in_ready, 0);
    tick();
    in_valid = 1'b0; in_is_key = 1'b0;
    check("key_in_stream_busy", busy, 1);
    check("key_in_stream_nosetkey", eng_set_key, 0);

    // Plaintext word 2 together with halt: word dropped, data_cnt cleared
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    in_valid = 1'b1; in_word = 32'h33333333; halt_req = 1'b1;
    tick();
    in_valid = 1'b0; halt_req = 1'b0;
    check("halt_pulse", eng_halt, 1);
    check("halt_busy_level", {busy, fifo_level}, 4'b0000);
    tick();
    check("halt_one_cycle", eng_halt, 0);
    tmp = PT0;
    for (int j = 0; j < 3; j++) send_word(tmp[127-32*j -: 32], 1'b0);
    check("datacnt_cleared_3w", fifo_level, 0);
    send_word(tmp[31:0], 1'b0);
    check("datacnt_cleared_4w", fifo_level, 1);

    // Halt in IDLE: flush and clear counts, no engine halt
    send_word(32'h77777777, 1'b0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("idle_halt_nopulse", eng_halt, 0);
    check("idle_halt_flush", fifo_level, 0);

    // Back-pressure: 2 blocks pre-loaded, 3 more sent from SET_KEY onward
    base = pops.size();
    send_block(blk[0]);
    send_block(blk[1]);
    check("bp_preload", fifo_level, 2);
    send_key(KEY);
    idx = 0; cyc = 0; blocked = 0; maxlvl = 0;
    while (idx < 12 && cyc < 60) begin
      wd = blk[2 + idx / 4];
      in_valid = 1'b1; in_is_key = 1'b0; in_word = wd[127-32*(idx%4) -: 32];
      #1;
      rdy = in_ready;
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
      if (idx == 11) begin
        if (!rdy) blocked++;
        else begin
          check("bp_pops_before_accept", pops.size() - base, 1);
          check("bp_pop_in_accept_cycle", eng_start, 1);
        end
      end
      tick();
      if (rdy) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 12);
    check("bp_max_level", maxlvl, 4);
    check("bp_blocked_cycles", blocked, 3);
    cyc = 0;
    while (pops.size() - base < 5 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("bp_pop_count", pops.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < pops.size()) check($sformatf("bp_blk%0d", i), pops[base + i], blk[i]);
    end

    // Halt in STREAM with 3 blocks buffered, then a fresh key load
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    send_block(blk[0]);
    send_block(blk[1]);
    send_block(blk[2]);
    check("halt3_preload", fifo_level, 3);
    key_load_check("k2");
    check("halt3_in_stream", {eng_start, fifo_level}, 4'b1011);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt3_pulse", {eng_halt, eng_start}, 2'b10);
    check("halt3_level_busy", {fifo_level, busy}, 4'b0000);
    tick();
    check("halt3_one_cycle", eng_halt, 0);
    key_load_check("k3");
    check("k3_empty_stream", {eng_start, busy}, 2'b01);

    // Reset for one cycle in WAIT
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    send_block(blk[3]);
    send_key(KEY);
    tick(); tick(); tick();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_strobes", {eng_set_key, eng_start, eng_halt, eng_prime}, 4'b0000);
    check("rstw_state_key", {eng_state, eng_key}, 256'd0);
    check("rstw_level_busy", {fifo_level, busy}, 4'b0000);
    tick();
    check("rstw_after", {eng_halt, eng_start, busy, fifo_level}, 6'b000000);

    check("strobe_exclusive", excl_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
